serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 106 ++++++++++
 tb/tb_serial_adder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first: one bit per clock, registered sum/cout.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             abit;
    logic             bbit;
    logic             sbit;
    logic             cnxt;
    logic             last;
    logic             accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (cnt == CW'(WIDTH - 1));

    always_comb begin
        abit         = areg[cnt];
        bbit         = breg[cnt];
        sbit         = abit ^ bbit ^ c;
        cnxt         = (abit & bbit) | (abit & c) | (bbit & c);
        acc_nxt      = acc;
        acc_nxt[cnt] = sbit;
    end

    // Partial sums build up in acc; sum only sees the completed word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            areg <= '0;
            breg <= '0;
            acc  <= '0;
            cnt  <= '0;
            c    <= 1'b0;
            sum  <= '0;
            cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf  <= 1'b0;
`endif
        end else if (accept) begin
            areg <= a;
            breg <= b;
            c    <= cin;
            acc  <= '0;
            cnt  <= '0;
        end else if (state == RUN) begin
            c   <= cnxt;
            acc <= acc_nxt;
            cnt <= cnt + CW'(1);
            if (last) begin
                sum  <= acc_nxt;
                cout <= cnxt;
`ifdef SERIAL_ADDER_OVF_EN
                ovf  <= c ^ cnxt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder (WIDTH=8 and WIDTH=1).
// Reference results come from plain integer addition.
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf;
    logic       ovf1;
`endif

    int         vectors;
    int         miscompares;
    logic [7:0] last_sum;
    logic       last_cout;

    serial_adder #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf  (ovf),
`endif
        .cout (cout)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .start(start1),
        .a    (a1),
        .b    (b1),
        .cin  (cin1),
        .busy (busy1),
        .done (done1),
        .sum  (sum1),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf  (ovf1),
`endif
        .cout (cout1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One 8-bit addition; optional stray start at mid_at, reset at rst_at.
    task automatic run8(input logic [7:0] ta,
                        input logic [7:0] tb,
                        input logic       tc,
                        input int         mid_at,
                        input int         rst_at);
        logic [8:0] full;
        logic       exp_v;
        logic [7:0] got_s;
        logic       got_c;
        logic       got_v;
        int         done_at;
        int         busy_n;
        int         done_n;
        int         held_bad;
        full     = 9'(ta) + 9'(tb) + 9'(tc);
        exp_v    = (ta[7] == tb[7]) && (full[7] != ta[7]);
        done_at  = -1;
        busy_n   = 0;
        done_n   = 0;
        held_bad = 0;
        got_s    = '0;
        got_c    = 1'b0;
        got_v    = 1'b0;
        start = 1'b1;
        a     = ta;
        b     = tb;
        cin   = tc;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_busy", 64'(busy), 64'(0));
                check("rst_done", 64'(done), 64'(0));
                check("rst_sum", 64'(sum), 64'(0));
                check("rst_cout", 64'(cout), 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
                check("rst_ovf", 64'(ovf), 64'(0));
`endif
                check("rst_nodone", 64'(done_n), 64'(0));
                rst       = 1'b0;
                last_sum  = '0;
                last_cout = 1'b0;
                return;
            end
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = k;
                    got_s   = sum;
                    got_c   = cout;
`ifdef SERIAL_ADDER_OVF_EN
                    got_v   = ovf;
`endif
                end
            end else if (done_n == 0 &&
                         (sum !== last_sum || cout !== last_cout)) begin
                held_bad++;
            end
            if (k == mid_at) begin
                start = 1'b1;
                a     = 8'hff;
                b     = 8'hff;
            end else begin
                start = 1'b0;
                a     = 8'($urandom);
                b     = 8'($urandom);
                cin   = 1'($urandom);
            end
        end
        check("latency", 64'(done_at), 64'(8));
        check("busy_cycles", 64'(busy_n), 64'(8));
        check("done_pulses", 64'(done_n), 64'(1));
        check("sum", 64'(got_s), 64'(full[7:0]));
        check("cout", 64'(got_c), 64'(full[8]));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", 64'(got_v), 64'(exp_v));
`else
        if (got_v !== 1'b0) check("ovf_absent", 64'(got_v), 64'(0));
        if (exp_v === 1'bx) check("ovf_model", 64'(exp_v), 64'(0));
`endif
        check("hold", 64'(held_bad), 64'(0));
        last_sum  = full[7:0];
        last_cout = full[8];
    endtask

    initial begin
        logic [7:0] qa[$];
        logic [7:0] qb[$];
        logic       qc[$];
        logic [8:0] full;
        logic [7:0] pa;
        logic [7:0] pb;
        logic       pc;
        int         n;
        int         last_done;
        vectors     = 0;
        miscompares = 0;
        last_sum    = '0;
        last_cout   = 1'b0;
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        cin1   = 1'b0;
        #2;
        check("init_busy", 64'(busy), 64'(0));
        check("init_done", 64'(done), 64'(0));
        check("init_sum", 64'(sum), 64'(0));
        check("init_cout", 64'(cout), 64'(0));
        check("init1_sum", 64'(sum1), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run8(8'hff, 8'h01, 1'b0, -1, -1);
        run8(8'ha5, 8'h5a, 1'b1, -1, -1);
        run8(8'h7f, 8'h01, 1'b0, -1, -1);
        run8(8'h80, 8'h80, 1'b0, -1, -1);
        run8(8'h10, 8'h20, 1'b0, 3, -1);
        run8(8'h55, 8'h66, 1'b1, -1, 4);
        run8(8'h03, 8'h04, 1'b0, -1, -1);
        for (int i = 0; i < 20; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), -1, -1);

        // Continuous start: each done re-accepts freshly driven operands.
        n         = 0;
        last_done = 0;
        start     = 1'b1;
        a         = 8'($urandom);
        b         = 8'($urandom);
        cin       = 1'($urandom);
        qa.push_back(a);
        qb.push_back(b);
        qc.push_back(cin);
        for (int e = 1; e <= 60 && n < 4; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                pa   = qa.pop_front();
                pb   = qb.pop_front();
                pc   = qc.pop_front();
                full = 9'(pa) + 9'(pb) + 9'(pc);
                check("stream_sum", 64'(sum), 64'(full[7:0]));
                check("stream_cout", 64'(cout), 64'(full[8]));
                check("stream_gap", 64'(e - last_done), 64'(n == 0 ? 9 : 9));
                last_done = e;
                n++;
                if (n == 4) begin
                    start = 1'b0;
                end else begin
                    a   = 8'($urandom);
                    b   = 8'($urandom);
                    cin = 1'($urandom);
                    qa.push_back(a);
                    qb.push_back(b);
                    qc.push_back(cin);
                end
            end
        end
        check("stream_count", 64'(n), 64'(4));
        @(posedge clk);
        #1;
        check("stream_idle", 64'(busy | done), 64'(0));

        // WIDTH=1: registered full adder, done one clock after start.
        for (int i = 0; i < 8; i++) begin
            a1     = 1'(i >> 2);
            b1     = 1'(i >> 1);
            cin1   = 1'(i);
            full   = 9'(a1) + 9'(b1) + 9'(cin1);
            start1 = 1'b1;
            @(posedge clk);
            #1;
            start1 = 1'b0;
            check("w1_busy", 64'(busy1), 64'(1));
            @(posedge clk);
            #1;
            check("w1_done", 64'(done1), 64'(1));
            check("w1_sum", 64'(sum1), 64'(full[0]));
            check("w1_cout", 64'(cout1), 64'(full[1]));
`ifdef SERIAL_ADDER_OVF_EN
            check("w1_ovf", 64'(ovf1), 64'(cin1 ^ full[1]));
`endif
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
